// File: rtl/mole_game_seq_if.sv
// mole_game_seq_if
// Groups the signals between the game sequencer and the blocks around it.
// The sequencer connects through the slave modport. The driver of the key,
// mole and sound-busy inputs connects through the master modport.
//   btn_pulse/btn_value : decoded key press, valid for one cycle
//   mole_mask           : bit i set = mole visible in hole i+1
//   snd_busy            : sound manager is playing
//   state..snd_mode     : registered sequencer outputs
interface mole_game_seq_if #(
    parameter int N_HOLES = 8,
    parameter int SCORE_W = 10
);
    logic               btn_pulse;
    logic [3:0]         btn_value;
    logic [N_HOLES-1:0] mole_mask;
    logic               snd_busy;
    logic [2:0]         state;
    logic [1:0]         stage;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [6:0]         timer;
    logic               play_en;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               snd_trig;
    logic [2:0]         snd_mode;

    modport master (
        output btn_pulse, btn_value, mole_mask, snd_busy,
        input  state, stage, lives, score, timer, play_en,
        input  hit_pulse, miss_pulse, snd_trig, snd_mode
    );

    modport slave (
        input  btn_pulse, btn_value, mole_mask, snd_busy,
        output state, stage, lives, score, timer, play_en,
        output hit_pulse, miss_pulse, snd_trig, snd_mode
    );
endinterface

// File: rtl/mole_game_seq.sv
// mole_game_seq
// Whack-a-mole game sequencer. It runs the READY / COUNTDOWN / PLAY / PAUSE
// flow and the three end screens. It keeps its own one-second tick and a
// seconds timer, and it scores hits with combo doubling and saturation. It
// also issues one-cycle sound requests to the sound manager.
// Ports:
//   clk_1mhz : system clock
//   rst      : asynchronous, active-high reset
//   bus      : slave side of mole_game_seq_if. Carries the key, mole and
//              sound-busy inputs, and the registered state, stage, lives,
//              score, timer, play_en, pulse and sound outputs.
module mole_game_seq #(
    parameter int N_HOLES       = 8,
    parameter int N_STAGES      = 3,
    parameter int MAX_LIVES     = 3,
    parameter int READY_SEC     = 3,
    parameter int STAGE_SEC     = 60,
    parameter int TICKS_PER_SEC = 1000000,
    parameter int SCORE_W       = 10,
    parameter int COMBO_TH      = 4,
    parameter int START_KEY     = 10,
    parameter int PAUSE_KEY     = 11
) (
    input  logic             clk_1mhz,
    input  logic             rst,
    mole_game_seq_if.slave   bus
);
    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        S_READY     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_STAGE_CLR = 3'd4,
        S_GAME_OVER = 3'd5,
        S_GAME_CLR  = 3'd6
    } state_e;

    typedef enum logic { PH_FIRE, PH_WAIT } phase_e;

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic [1:0]         stage_q, stage_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [6:0]         timer_q, timer_d;
    logic [3:0]         combo_q, combo_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               play_en_q, play_en_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic               snd_trig_q, snd_trig_d;
    logic [2:0]         snd_mode_q, snd_mode_d;

    logic               start_press, pause_press, hole_press, hole_hit;
    logic               tick_wrap;
    logic [SCORE_W:0]   score_sum;

    assign start_press = bus.btn_pulse && (bus.btn_value == 4'(START_KEY));
    assign pause_press = bus.btn_pulse && (bus.btn_value == 4'(PAUSE_KEY));
    assign tick_wrap   = (tick_q == TICK_LAST);
    // Extra top bit catches overflow so the score can saturate.
    assign score_sum   = {1'b0, score_q} +
                         ((combo_q >= 4'(COMBO_TH)) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));

    // Map the key code onto a hole. Codes outside 1..N_HOLES never match.
    always_comb begin
        hole_press = 1'b0;
        hole_hit   = 1'b0;
        for (int i = 0; i < N_HOLES; i++) begin
            if (bus.btn_value == 4'(i + 1)) begin
                hole_press = bus.btn_pulse;
                hole_hit   = bus.mole_mask[i];
            end
        end
    end

    // Next-state logic for the whole sequencer.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        wait_cnt_d   = wait_cnt_q;
        stage_d      = stage_q;
        lives_d      = lives_q;
        score_d      = score_q;
        timer_d      = timer_q;
        combo_d      = combo_q;
        tick_d       = tick_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        snd_trig_d   = 1'b0;
        snd_mode_d   = snd_mode_q;

        case (state_q)
            S_READY: begin
                tick_d = '0;
                if (start_press) begin
                    state_d = S_COUNTDOWN;
                    timer_d = 7'(READY_SEC);
                    // A start from stage 0 begins a fresh game.
                    if (stage_q == 2'd0) begin
                        score_d = '0;
                        combo_d = 4'd0;
                        lives_d = 2'(MAX_LIVES);
                    end
                end
            end

            S_COUNTDOWN: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap) begin
                    // The zero second is shown for a full second before play.
                    if (timer_q == 7'd0) begin
                        state_d = S_PLAY;
                        timer_d = 7'(STAGE_SEC);
                    end else begin
                        timer_d = timer_q - 7'd1;
                        // A beep is dropped while the sound manager is busy.
                        if (!bus.snd_busy) begin
                            snd_trig_d = 1'b1;
                            snd_mode_d = (timer_q >= 7'd2) ? 3'd1 : 3'd2;
                        end
                    end
                end
            end

            S_PLAY: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap && timer_q != 7'd0) begin
                    timer_d = timer_q - 7'd1;
                end
                if (lives_q == 2'd0) begin
                    state_d = S_GAME_OVER;
                end else begin
                    if (hole_press && hole_hit) begin
                        score_d     = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        combo_d     = (combo_q == 4'd15) ? combo_q : combo_q + 4'd1;
                        hit_pulse_d = 1'b1;
                        snd_trig_d  = 1'b1;
                        snd_mode_d  = 3'd3;
                    end else if (hole_press) begin
                        lives_d      = lives_q - 2'd1;
                        combo_d      = 4'd0;
                        miss_pulse_d = 1'b1;
                        snd_trig_d   = 1'b1;
                        snd_mode_d   = 3'd4;
                    end
                    // A final miss at expiry ends the game rather than the stage.
                    if (hole_press && !hole_hit && lives_q == 2'd1 && timer_q == 7'd0) begin
                        state_d = S_GAME_OVER;
                    end else if (timer_q == 7'd0) begin
                        state_d = (stage_q < 2'(N_STAGES - 1)) ? S_STAGE_CLR : S_GAME_CLR;
                    end else if (pause_press) begin
                        state_d = S_PAUSE;
                    end
                end
            end

            S_PAUSE: begin
                if (pause_press) begin
                    state_d = S_PLAY;
                end
            end

            S_STAGE_CLR, S_GAME_OVER, S_GAME_CLR: begin
                tick_d = '0;
                if (phase_q == PH_FIRE) begin
                    if (!bus.snd_busy) begin
                        snd_trig_d = 1'b1;
                        case (state_q)
                            S_STAGE_CLR: snd_mode_d = 3'd5;
                            S_GAME_OVER: snd_mode_d = 3'd6;
                            default:     snd_mode_d = 3'd7;
                        endcase
                        phase_d    = PH_WAIT;
                        wait_cnt_d = 2'd0;
                    end
                end else begin
                    // Wait covers the cycles snd_busy may need to rise.
                    if (wait_cnt_q != 2'd2) begin
                        wait_cnt_d = wait_cnt_q + 2'd1;
                    end
                    if (wait_cnt_q == 2'd2 && !bus.snd_busy) begin
                        phase_d = PH_FIRE;
                        state_d = S_READY;
                        stage_d = (state_q == S_STAGE_CLR) ? stage_q + 2'd1 : 2'd0;
                    end
                end
            end

            default: state_d = S_READY;
        endcase

        play_en_d = (state_d == S_PLAY);
    end

    // State registers. Reset drops any pending sound immediately.
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state_q      <= S_READY;
            phase_q      <= PH_FIRE;
            wait_cnt_q   <= 2'd0;
            stage_q      <= 2'd0;
            lives_q      <= 2'(MAX_LIVES);
            score_q      <= '0;
            timer_q      <= 7'd0;
            combo_q      <= 4'd0;
            tick_q       <= '0;
            play_en_q    <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            snd_trig_q   <= 1'b0;
            snd_mode_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            wait_cnt_q   <= wait_cnt_d;
            stage_q      <= stage_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            timer_q      <= timer_d;
            combo_q      <= combo_d;
            tick_q       <= tick_d;
            play_en_q    <= play_en_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            snd_trig_q   <= snd_trig_d;
            snd_mode_q   <= snd_mode_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.stage      = stage_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.timer      = timer_q;
    assign bus.play_en    = play_en_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.snd_trig   = snd_trig_q;
    assign bus.snd_mode   = snd_mode_q;
endmodule

// File: tb/tb_mole_game_seq.sv
// tb_mole_game_seq
// Directed bench for mole_game_seq with a short second (10 clocks), two
// stages and a 3-bit score. It walks through the countdown, hits with combo
// and saturation, pause, misses to game over, stage clear and game clear,
// and then a reset taken from pause.
module tb_mole_game_seq;
    localparam int TPS = 10;

    logic clk_1mhz = 1'b0;
    logic rst      = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   n;
    int   trigs;
    int   exp_score [7] = '{1, 2, 3, 4, 6, 7, 7};

    always #5 clk_1mhz = ~clk_1mhz;

    mole_game_seq_if #(.N_HOLES(8), .SCORE_W(3)) bus ();

    mole_game_seq #(
        .N_HOLES(8), .N_STAGES(2), .MAX_LIVES(3), .READY_SEC(3),
        .STAGE_SEC(60), .TICKS_PER_SEC(TPS), .SCORE_W(3), .COMBO_TH(4),
        .START_KEY(10), .PAUSE_KEY(11)
    ) dut (
        .clk_1mhz(clk_1mhz),
        .rst(rst),
        .bus(bus)
    );

    // One comparison: counted, and reported when it fails.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk_1mhz);
    endtask

    // One-cycle key press. Returns at the negedge where its effect is visible.
    task automatic apply_stimulus(input logic [3:0] key);
        bus.btn_value = key;
        bus.btn_pulse = 1'b1;
        @(negedge clk_1mhz);
        bus.btn_pulse = 1'b0;
    endtask

    task automatic wait_trig(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_1mhz);
            cnt++;
        end while (!bus.snd_trig && cnt < limit);
        if (!bus.snd_trig) cnt = -1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int k = 0;
        while (bus.state !== s && k < limit) begin
            @(negedge clk_1mhz);
            k++;
        end
        check_output(tag, bus.state, s);
    endtask

    task automatic wait_timer(input logic [6:0] t, input int limit, input string tag);
        int k = 0;
        while (bus.timer !== t && k < limit) begin
            @(negedge clk_1mhz);
            k++;
        end
        check_output(tag, bus.timer, t);
    endtask

    initial begin
        bus.btn_pulse = 1'b0;
        bus.btn_value = 4'd0;
        bus.mole_mask = '0;
        bus.snd_busy  = 1'b0;
        step(3);
        check_output("rst_state", bus.state, 0);
        check_output("rst_stage", bus.stage, 0);
        check_output("rst_lives", bus.lives, 3);
        check_output("rst_score", bus.score, 0);
        check_output("rst_timer", bus.timer, 0);
        check_output("rst_trig", bus.snd_trig, 0);
        check_output("rst_mode", bus.snd_mode, 0);
        rst = 1'b0;
        step(2);

        // Non-start keys are ignored in READY.
        apply_stimulus(4'd3);
        check_output("ready_ign_hole", bus.state, 0);
        apply_stimulus(4'd11);
        check_output("ready_ign_pause", bus.state, 0);

        // Countdown: three beeps 10 cycles apart, then PLAY one second later.
        apply_stimulus(4'd10);
        check_output("cd_state", bus.state, 1);
        check_output("cd_timer", bus.timer, 3);
        for (int b = 0; b < 3; b++) begin
            wait_trig(20, n);
            check_output("cd_beep_gap", n, 10);
            check_output("cd_beep_mode", bus.snd_mode, (b < 2) ? 1 : 2);
            check_output("cd_beep_timer", bus.timer, 2 - b);
        end
        step(9);
        check_output("cd_hold", bus.state, 1);
        step(1);
        check_output("play_state", bus.state, 2);
        check_output("play_timer", bus.timer, 60);
        check_output("play_en", bus.play_en, 1);

        // Key 0 and key 9 (above N_HOLES) are ignored.
        bus.mole_mask = 8'b0000_0100;
        apply_stimulus(4'd0);
        check_output("ign0_hit", bus.hit_pulse, 0);
        check_output("ign0_miss", bus.miss_pulse, 0);
        apply_stimulus(4'd9);
        check_output("ign9_miss", bus.miss_pulse, 0);
        check_output("ign9_lives", bus.lives, 3);

        // Hits on hole 3: combo doubles from the fifth hit, score saturates at 7.
        for (int h = 0; h < 7; h++) begin
            apply_stimulus(4'd3);
            check_output("hit_score", bus.score, exp_score[h]);
            check_output("hit_pulse", bus.hit_pulse, 1);
            check_output("hit_trig", bus.snd_trig, 1);
            check_output("hit_mode", bus.snd_mode, 3);
        end

        // Pause at timer 40, four ticks into the second.
        wait_timer(7'd40, 400, "pause_reach40");
        step(3);
        apply_stimulus(4'd11);
        check_output("pause_state", bus.state, 3);
        check_output("pause_play_en", bus.play_en, 0);
        step(50);
        check_output("pause_timer", bus.timer, 40);
        check_output("pause_hold", bus.state, 3);
        apply_stimulus(4'd11);
        check_output("resume_state", bus.state, 2);
        check_output("resume_play_en", bus.play_en, 1);
        n = 0;
        while (bus.timer == 7'd40 && n < 20) begin
            @(negedge clk_1mhz);
            n++;
        end
        check_output("resume_gap", n, TPS - 4);
        check_output("resume_timer", bus.timer, 39);

        // Misses on empty holes. The miss sound is requested even while busy.
        bus.mole_mask = '0;
        bus.snd_busy  = 1'b1;
        apply_stimulus(4'd5);
        check_output("miss1_lives", bus.lives, 2);
        check_output("miss1_pulse", bus.miss_pulse, 1);
        check_output("miss1_trig", bus.snd_trig, 1);
        check_output("miss1_mode", bus.snd_mode, 4);
        apply_stimulus(4'd1);
        check_output("miss2_lives", bus.lives, 1);
        apply_stimulus(4'd8);
        check_output("miss3_lives", bus.lives, 0);
        check_output("miss3_state", bus.state, 2);
        step(1);
        check_output("go_state", bus.state, 5);
        check_output("go_play_en", bus.play_en, 0);
        trigs = 0;
        repeat (3) begin
            step(1);
            trigs += int'(bus.snd_trig);
        end
        check_output("go_busy_notrig", trigs, 0);
        bus.snd_busy = 1'b0;
        step(1);
        check_output("go_trig", bus.snd_trig, 1);
        check_output("go_mode", bus.snd_mode, 6);
        bus.snd_busy = 1'b1;
        trigs = 0;
        repeat (5) begin
            step(1);
            trigs += int'(bus.snd_trig);
        end
        check_output("go_single_trig", trigs, 0);
        check_output("go_wait_busy", bus.state, 5);
        bus.snd_busy = 1'b0;
        wait_state(3'd0, 10, "go_exit");
        check_output("go_exit_stage", bus.stage, 0);
        check_output("go_held_lives", bus.lives, 0);
        check_output("go_held_score", bus.score, 7);

        // New game, stage 0: a hit in the expiry cycle still scores.
        apply_stimulus(4'd10);
        check_output("g2_state", bus.state, 1);
        check_output("g2_score", bus.score, 0);
        check_output("g2_lives", bus.lives, 3);
        wait_state(3'd2, 60, "g2_play");
        bus.mole_mask = 8'b1000_0000;
        wait_timer(7'd0, 700, "g2_expiry");
        check_output("g2_still_play", bus.state, 2);
        apply_stimulus(4'd8);
        check_output("sc_state", bus.state, 4);
        check_output("sc_hit_score", bus.score, 1);
        check_output("sc_hit_pulse", bus.hit_pulse, 1);
        step(1);
        check_output("sc_trig", bus.snd_trig, 1);
        check_output("sc_mode", bus.snd_mode, 5);
        wait_state(3'd0, 10, "sc_exit");
        check_output("sc_stage", bus.stage, 1);

        // Stage 1 start keeps score and lives; expiry ends in GAME_CLR.
        apply_stimulus(4'd10);
        check_output("s1_state", bus.state, 1);
        check_output("s1_score_kept", bus.score, 1);
        wait_state(3'd2, 60, "s1_play");
        wait_timer(7'd0, 700, "s1_expiry");
        step(1);
        check_output("gc_state", bus.state, 6);
        step(1);
        check_output("gc_trig", bus.snd_trig, 1);
        check_output("gc_mode", bus.snd_mode, 7);
        wait_state(3'd0, 10, "gc_exit");
        check_output("gc_stage", bus.stage, 0);

        // Reset taken while paused returns every output to its reset value.
        apply_stimulus(4'd10);
        wait_state(3'd2, 60, "r_play");
        apply_stimulus(4'd8);
        apply_stimulus(4'd2);
        check_output("r_lives_pre", bus.lives, 2);
        apply_stimulus(4'd11);
        check_output("r_pause", bus.state, 3);
        rst = 1'b1;
        step(1);
        check_output("r_state", bus.state, 0);
        check_output("r_stage", bus.stage, 0);
        check_output("r_lives", bus.lives, 3);
        check_output("r_score", bus.score, 0);
        check_output("r_timer", bus.timer, 0);
        check_output("r_play_en", bus.play_en, 0);
        check_output("r_pulses", {bus.hit_pulse, bus.miss_pulse, bus.snd_trig}, 0);
        check_output("r_mode", bus.snd_mode, 0);
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
